// File: rtl/btn_pkg.sv
// Shared state encoding and default timing constants for the two-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 25 MHz clock: 10 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_EN       = 1;
  localparam int DEF_REPEAT_DELAY    = 12500000;
  localparam int DEF_REPEAT_PERIOD   = 2500000;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, stability and auto-repeat counters.
module button_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic raw,
  output logic db,
  output logic press
);

  localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = imax(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_MAX    = RW'(RMAX);

  logic [1:0]    sync_q;
  logic          sync;
  btn_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [RW-1:0] rcnt, rcnt_nxt, rcnt_inc;
  logic          rphase, rphase_nxt;  // 0: waiting first repeat, 1: periodic repeats
  logic          press_nxt;

  assign sync     = sync_q[1];
  assign cnt_inc  = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
  assign rcnt_inc = (rcnt == R_MAX) ? rcnt : rcnt + 1'b1;
  assign db       = (state == HELD) || (state == RELEASE_WAIT);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q <= '0;
      state  <= RELEASED;
      cnt    <= '0;
      rcnt   <= '0;
      rphase <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rcnt   <= rcnt_nxt;
      rphase <= rphase_nxt;
      press  <= press_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rcnt_nxt   = rcnt;
    rphase_nxt = rphase;
    press_nxt  = 1'b0;
    case (state)
      RELEASED: if (sync) begin
        state_nxt = PRESS_WAIT;
        cnt_nxt   = '0;
      end
      PRESS_WAIT: if (!sync) begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end else if (cnt_inc == CNT_LAST) begin
        state_nxt  = HELD;
        cnt_nxt    = '0;
        rcnt_nxt   = '0;
        rphase_nxt = 1'b0;
        press_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt_inc;
      end
      HELD: if (!sync) begin
        state_nxt = RELEASE_WAIT;
        cnt_nxt   = '0;
      end else if (REPEAT_EN != 0) begin
        if (rcnt_inc == (rphase ? R_PERIOD : R_DELAY)) begin
          rcnt_nxt   = '0;
          rphase_nxt = 1'b1;
          press_nxt  = 1'b1;
        end else begin
          rcnt_nxt = rcnt_inc;
        end
      end
      // repeat counter is left untouched here so a short release glitch only pauses it
      RELEASE_WAIT: if (sync) begin
        state_nxt = HELD;
        cnt_nxt   = '0;
      end else if (cnt_inc == CNT_LAST) begin
        state_nxt  = RELEASED;
        cnt_nxt    = '0;
        rcnt_nxt   = '0;
        rphase_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt_inc;
      end
      default: state_nxt = RELEASED;
    endcase
  end

endmodule

// File: rtl/button_debounce_pair.sv
// Two debounced buttons driving registered up/down commands; a held button locks out the other.
module button_debounce_pair
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_B1,
  input  logic i_B2,
  output logic o_B1_db,
  output logic o_B2_db,
  output logic o_B1_press,
  output logic o_B2_press,
  output logic o_Up,
  output logic o_Down
);

  logic [1:0] db, press;

  button_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (REPEAT_EN),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_ch [1:0] (
    .gclk  (i_Clk),
    .grst_n(i_Rst_n),
    .raw   ({i_B2, i_B1}),
    .db    (db),
    .press (press)
  );

  assign o_B1_db    = db[0];
  assign o_B2_db    = db[1];
  assign o_B1_press = press[0];
  assign o_B2_press = press[1];

  // a press always coincides with its own db=1, so up and down can never both fire
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Up   <= 1'b0;
      o_Down <= 1'b0;
    end else begin
      o_Up   <= press[0] & ~db[1];
      o_Down <= press[1] & ~db[0];
    end
  end

endmodule
